mem_stage: RTL and testbench

Memory-access stage of the FirstRV pipeline, directly downstream of the 32-bit ALU. It accepts an executed instruction (ALU result, zero flag, store data, control) and either passes the ALU result through to writeback or performs a load/store on the data memory through a request/grant/response handshake. Its outputs are the writeback result, byte-lane-formatted memory traffic, branch resolution (BEQ taken = zero flag) and a misalignment flag. It stalls upstream while a memory transaction is outstanding.

---
 rtl/mem_stage.sv | 175 +++++++++++++++++
 tb/tb_mem_stage.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - FirstRV memory-access stage: ALU pass-through, load/store over req/gnt/rvalid, writeback
module mem_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] alu_out,
  input  logic            zero,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [2:0]      funct3,
  input  logic            branch,
  input  logic [4:0]      rd,
  input  logic            reg_write,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic            wb_we,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            br_taken,
  output logic            misalign
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t          state, state_n;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] store_q;
  logic [2:0]      funct3_q;
  logic            we_q;
  logic [4:0]      rd_q;
  logic            reg_write_q;

  logic            accept;
  logic            is_mem;
  logic            in_misalign;
  logic [3:0]      be_n;
  logic [XLEN-1:0] wdata_n;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] load_ext;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid & in_ready;
  assign is_mem   = mem_read | mem_write;

  // funct3[1:0]: 00 byte, 01 half, 1x word (reserved encodings fall into word)
  assign in_misalign = ((funct3[1:0] == 2'b01) & alu_out[0]) |
                       (funct3[1] & (alu_out[1:0] != 2'b00));

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (accept && is_mem && !in_misalign) state_n = REQ;
      REQ:  if (dmem_gnt) state_n = we_q ? IDLE : WAIT;
      WAIT: if (dmem_rvalid) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    be_n    = 4'b0000;
    wdata_n = store_q;
    case (funct3_q[1:0])
      2'b00: begin
        be_n    = 4'b0001 << addr_q[1:0];
        wdata_n = {4{store_q[7:0]}};
      end
      2'b01: begin
        be_n    = 4'b0011 << addr_q[1:0];
        wdata_n = {2{store_q[15:0]}};
      end
      default: begin
        be_n    = 4'b1111;
        wdata_n = store_q;
      end
    endcase
  end

  assign dmem_req   = (state == REQ);
  assign dmem_we    = dmem_req & we_q;
  assign dmem_addr  = dmem_req ? {addr_q[XLEN-1:2], 2'b00} : '0;
  assign dmem_be    = dmem_req ? be_n : 4'b0000;
  assign dmem_wdata = dmem_req ? wdata_n : '0;

  // Bring the addressed lane down to bit 0, then extend by size/signedness.
  assign shifted = dmem_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    load_ext = shifted;
    case (funct3_q)
      3'b000:  load_ext = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      3'b100:  load_ext = {{(XLEN-8){1'b0}}, shifted[7:0]};
      3'b001:  load_ext = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      3'b101:  load_ext = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      store_q     <= '0;
      funct3_q    <= 3'b000;
      we_q        <= 1'b0;
      rd_q        <= 5'd0;
      reg_write_q <= 1'b0;
      wb_valid    <= 1'b0;
      wb_we       <= 1'b0;
      wb_rd       <= 5'd0;
      wb_data     <= '0;
      br_taken    <= 1'b0;
      misalign    <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      br_taken <= 1'b0;
      misalign <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q      <= alu_out;
            store_q     <= rs2_data;
            funct3_q    <= funct3;
            we_q        <= mem_write;
            rd_q        <= rd;
            reg_write_q <= reg_write;
            if (!is_mem) begin
              wb_valid <= 1'b1;
              wb_we    <= reg_write;
              wb_rd    <= rd;
              wb_data  <= alu_out;
              br_taken <= branch & zero;
            end else if (in_misalign) begin
              wb_valid <= 1'b1;
              wb_we    <= 1'b0;
              wb_rd    <= rd;
              misalign <= 1'b1;
            end
          end
        end
        REQ: begin
          if (dmem_gnt && we_q) begin
            wb_valid <= 1'b1;
            wb_we    <= 1'b0;
            wb_rd    <= rd_q;
          end
        end
        WAIT: begin
          if (dmem_rvalid) begin
            wb_valid <= 1'b1;
            wb_we    <= reg_write_q;
            wb_rd    <= rd_q;
            wb_data  <= load_ext;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_out;
  logic        zero;
  logic [31:0] rs2_data;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic        branch;
  logic [4:0]  rd;
  logic        reg_write;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        br_taken;
  logic        misalign;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_out(alu_out), .zero(zero), .rs2_data(rs2_data),
    .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .branch(branch), .rd(rd), .reg_write(reg_write),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .br_taken(br_taken), .misalign(misalign)
  );

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    alu_out   = 32'h0;
    zero      = 1'b0;
    rs2_data  = 32'h0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    funct3    = 3'b000;
    branch    = 1'b0;
    rd        = 5'd0;
    reg_write = 1'b0;
  endtask

  // Load with gnt immediately (rvalid also driven with gnt, which must be ignored),
  // one empty WAIT cycle, then rvalid.
  task automatic do_load(input string tag, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] exp);
    idle_inputs();
    in_valid = 1'b1; mem_read = 1'b1; reg_write = 1'b1; rd = 5'd7;
    alu_out = addr; funct3 = f3;
    step();
    chk1({tag, "_req"}, dmem_req, 1'b1);
    chk1({tag, "_we"}, dmem_we, 1'b0);
    chk32({tag, "_addr"}, dmem_addr, 32'h0000_0200);
    chk1({tag, "_rdy_req"}, in_ready, 1'b0);
    idle_inputs();
    dmem_gnt = 1'b1; dmem_rvalid = 1'b1;
    step();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    chk1({tag, "_early_wb"}, wb_valid, 1'b0);
    chk1({tag, "_rdy_wait"}, in_ready, 1'b0);
    chk1({tag, "_req_wait"}, dmem_req, 1'b0);
    step();
    chk1({tag, "_wait_hold"}, wb_valid, 1'b0);
    dmem_rvalid = 1'b1;
    step();
    dmem_rvalid = 1'b0;
    chk1({tag, "_wbv"}, wb_valid, 1'b1);
    chk32({tag, "_data"}, wb_data, exp);
    chk1({tag, "_wbwe"}, wb_we, 1'b1);
    chk32({tag, "_rd"}, {27'b0, wb_rd}, 32'd7);
    chk1({tag, "_rdy_done"}, in_ready, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h80F0_1234;
    step();
    step();
    chk1("rst_wbv", wb_valid, 1'b0);
    chk1("rst_rdy", in_ready, 1'b1);
    chk1("rst_req", dmem_req, 1'b0);
    chk32("rst_wbdata", wb_data, 32'h0);
    chk32("rst_be", {28'b0, dmem_be}, 32'h0);
    chk1("rst_mis", misalign, 1'b0);
    rst = 1'b0;

    // ALU pass-through
    in_valid = 1'b1; alu_out = 32'd30; reg_write = 1'b1; rd = 5'd5;
    step();
    chk1("pt_wbv", wb_valid, 1'b1);
    chk32("pt_data", wb_data, 32'd30);
    chk32("pt_rd", {27'b0, wb_rd}, 32'd5);
    chk1("pt_we", wb_we, 1'b1);
    chk1("pt_br", br_taken, 1'b0);
    chk1("pt_req", dmem_req, 1'b0);
    idle_inputs();
    step();
    chk1("pt_pulse", wb_valid, 1'b0);
    chk32("pt_hold", wb_data, 32'd30);

    // Branch taken then not taken, back to back
    in_valid = 1'b1; branch = 1'b1; zero = 1'b1; alu_out = 32'h0;
    step();
    chk1("br1_wbv", wb_valid, 1'b1);
    chk1("br1_taken", br_taken, 1'b1);
    chk1("br1_we", wb_we, 1'b0);
    zero = 1'b0;
    step();
    chk1("br0_wbv", wb_valid, 1'b1);
    chk1("br0_taken", br_taken, 1'b0);
    idle_inputs();
    step();
    chk1("br_idle", br_taken, 1'b0);

    // Store byte at 0x103, gnt delayed 2 cycles
    in_valid = 1'b1; mem_write = 1'b1; alu_out = 32'h103; rs2_data = 32'h0000_00AB;
    funct3 = 3'b000; rd = 5'd3;
    step();
    idle_inputs();
    chk1("sb_req1", dmem_req, 1'b1);
    chk1("sb_we", dmem_we, 1'b1);
    chk32("sb_addr", dmem_addr, 32'h100);
    chk32("sb_be", {28'b0, dmem_be}, 32'h8);
    chk32("sb_wdata", dmem_wdata, 32'hABAB_ABAB);
    chk1("sb_rdy", in_ready, 1'b0);
    step();
    chk1("sb_req2", dmem_req, 1'b1);
    chk32("sb_addr2", dmem_addr, 32'h100);
    step();
    chk1("sb_req3", dmem_req, 1'b1);
    chk1("sb_rdy3", in_ready, 1'b0);
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    chk1("sb_wbv", wb_valid, 1'b1);
    chk1("sb_wbwe", wb_we, 1'b0);
    chk1("sb_req_off", dmem_req, 1'b0);
    chk32("sb_be_off", {28'b0, dmem_be}, 32'h0);
    chk32("sb_wdata_off", dmem_wdata, 32'h0);
    chk1("sb_rdy_done", in_ready, 1'b1);

    // Store half at 0x102, immediate gnt
    in_valid = 1'b1; mem_write = 1'b1; alu_out = 32'h102; rs2_data = 32'h1234_CDEF;
    funct3 = 3'b001;
    step();
    idle_inputs();
    chk32("sh_be", {28'b0, dmem_be}, 32'hC);
    chk32("sh_wdata", dmem_wdata, 32'hCDEF_CDEF);
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    chk1("sh_wbv", wb_valid, 1'b1);

    // Loads from word 0x80F01234 at 0x200
    do_load("lb",  3'b000, 32'h203, 32'hFFFF_FF80);
    do_load("lbu", 3'b100, 32'h203, 32'h0000_0080);
    do_load("lh",  3'b001, 32'h202, 32'hFFFF_80F0);
    do_load("lw",  3'b010, 32'h200, 32'h80F0_1234);
    do_load("lhu", 3'b101, 32'h200, 32'h0000_1234);
    do_load("lb0", 3'b000, 32'h200, 32'h0000_0034);

    // Misaligned LW at 0x102
    in_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; alu_out = 32'h102;
    reg_write = 1'b1; rd = 5'd9;
    step();
    idle_inputs();
    chk1("mis_wbv", wb_valid, 1'b1);
    chk1("mis_flag", misalign, 1'b1);
    chk1("mis_we", wb_we, 1'b0);
    chk1("mis_req", dmem_req, 1'b0);
    chk1("mis_rdy", in_ready, 1'b1);
    step();
    chk1("mis_clear", misalign, 1'b0);
    chk1("mis_req2", dmem_req, 1'b0);

    // Reset while in WAIT, then a late rvalid
    in_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; alu_out = 32'h200; reg_write = 1'b1;
    step();
    idle_inputs();
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    chk1("rw_in_wait", in_ready, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk1("rw_req", dmem_req, 1'b0);
    chk1("rw_wbv", wb_valid, 1'b0);
    chk1("rw_rdy", in_ready, 1'b1);
    dmem_rvalid = 1'b1;
    step();
    dmem_rvalid = 1'b0;
    chk1("rw_late", wb_valid, 1'b0);
    chk1("rw_rdy2", in_ready, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
